seq_restoring_divider: RTL and testbench



---
 rtl/div_pkg.sv | 29 ++
 rtl/trial_subtractor.sv | 29 ++
 rtl/seq_restoring_divider.sv | 147 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Bits needed to count down from value-1 to zero (at least 1).
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // 1-bit full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/trial_subtractor.sv
// Ripple-borrow subtractor built from full-adder cells: minuend + ~subtrahend + 1.
module trial_subtractor
  import div_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] minuend_i,
  input  logic [N-1:0] subtrahend_i,
  output logic [N-1:0] difference_o,
  output logic         no_borrow_o
);

  logic       carry_s;
  logic [1:0] cell_s;

  // Carry chain; a final carry of 1 means the subtraction did not borrow.
  always_comb begin
    carry_s      = 1'b1;
    cell_s       = 2'b00;
    difference_o = '0;
    for (int i = 0; i < N; i++) begin
      cell_s          = full_add(minuend_i[i], ~subtrahend_i[i], carry_s);
      difference_o[i] = cell_s[0];
      carry_s         = cell_s[1];
    end
    no_borrow_o = carry_s;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional divide-by-zero fast path enabled by defining DIVIDER_ZERO_FAST_EN.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = clog2(W);

  div_state_e    state_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  dvd_q;
  logic [W-1:0]  dvs_q;
  logic [W:0]    rem_q;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  rmd_q;

  logic [W:0]    shift_s;
  logic [W:0]    diff_s;
  logic          no_borrow_s;
  logic [W:0]    rem_d;
  logic [W-1:0]  dvd_d;
  logic          rem_unused_s;

  // After a restore R is always below the divisor, so its top bit never feeds the shift.
  assign rem_unused_s = rem_q[W];

  // Shift the next dividend bit into the partial remainder.
  always_comb begin
    shift_s = {rem_q[W-1:0], dvd_q[W-1]};
  end

  trial_subtractor #(
    .N(W + 1)
  ) u_sub (
    .minuend_i   (shift_s),
    .subtrahend_i({1'b0, dvs_q}),
    .difference_o(diff_s),
    .no_borrow_o (no_borrow_s)
  );

  // Restore decision; quotient bits are collected in the vacated dividend LSBs.
  always_comb begin
    if (no_borrow_s) begin
      rem_d = diff_s;
    end else begin
      rem_d = shift_s;
    end
    dvd_d = {dvd_q[W-2:0], no_borrow_s};
  end

`ifdef DIVIDER_ZERO_FAST_EN
  logic dbz_q;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
`ifdef DIVIDER_ZERO_FAST_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            rem_q   <= '0;
            count_q <= CW'(W - 1);
            busy_q  <= 1'b1;
`ifdef DIVIDER_ZERO_FAST_EN
            if (divisor == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              quo_q   <= '1;
              rmd_q   <= dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= ST_CALC;
              dbz_q   <= 1'b0;
            end
`else
            state_q <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (count_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            quo_q   <= dvd_d;
            rmd_q   <= rem_d[W-1:0];
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
`ifdef DIVIDER_ZERO_FAST_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (W=8); expectations follow DIVIDER_ZERO_FAST_EN.
module tb_seq_restoring_divider;

  localparam int W = 8;

`ifdef DIVIDER_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   cyc;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  seq_restoring_divider #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drives one accepted request for a single cycle and records its expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.q   = (b == '0) ? {W{1'b1}} : W'(a / b);
    e.r   = (b == '0) ? a : W'(a % b);
    e.dbz = FAST && (b == '0);
    e.lat = (FAST && (b == '0)) ? 1 : W + 1;
    e.cyc = cyc;
    sb_q.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_wait", busy, 0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Output monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dbz);
        check("latency", cyc - e.cyc, e.lat);
        if (e.b != '0) begin
          check("recompose", int'(quotient) * int'(divisor_of(e)) + int'(remainder), int'(e.a));
          check("rem_lt_div", (remainder < e.b) ? 1 : 0, 1);
        end
      end
    end
  end

  function automatic logic [W-1:0] divisor_of(input exp_t e);
    return e.b;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 8'd10;
    divisor  = 8'd3;
    step(3);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    step(1);
    check("start_in_rst_ignored", busy, 0);

    // 100/7 with busy profile over cycles 1..9
    issue(8'd100, 8'd7);
    for (int k = 1; k <= W + 1; k++) begin
      check("busy_profile", busy, 1);
      step(1);
    end
    check("busy_cleared", busy, 0);

    // back-to-back 255/1 then 5/9
    issue(8'd255, 8'd1);
    wait_idle();
    issue(8'd5, 8'd9);
    wait_idle();

    // divide by zero
    issue(8'd200, 8'd0);
    wait_idle();

    // start while busy is ignored
    issue(8'd50, 8'd3);
    step(3);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    step(1);
    start = 1'b0;
    wait_idle();
    step(1);
    check("held_quotient", quotient, 16);
    check("held_remainder", remainder, 2);

    // reset mid-operation aborts without done
    issue(8'd77, 8'd5);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    sb_q.delete();
    check("abort_busy", busy, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    for (int k = 0; k < W + 2; k++) begin
      check("abort_no_done", done, 0);
      step(1);
    end
    issue(8'd77, 8'd5);
    wait_idle();

    // randomized operands
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom_range(0, 255));
      b = (i % 50 == 0) ? 8'd0 : W'($urandom_range(0, 255));
      issue(a, b);
      wait_idle();
    end

    n = 0;
    while (sb_q.size() != 0 && n < 64) begin
      step(1);
      n++;
    end
    check("scoreboard_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
